// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_arbiter
// Description : Round-robin sharing of one combinational ALU between two
//               requesters, with registered operands, a valid/ready response
//               channel and saturating per-requester grant counters.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_share_arbiter #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [2*DATA_W-1:0]   req_a,
    input  logic [2*DATA_W-1:0]   req_b,
    input  logic [7:0]            req_op,
    output logic [1:0]            rsp_valid,
    input  logic [1:0]            rsp_ready,
    output logic [DATA_W-1:0]     rsp_result,
    output logic                  rsp_zero,
    output logic                  rsp_illegal,
    output logic [DATA_W-1:0]     alu_a,
    output logic [DATA_W-1:0]     alu_b,
    output logic [3:0]            alu_op,
    input  logic [DATA_W-1:0]     alu_result,
    input  logic                  alu_zero,
    output logic                  busy,
    output logic [CNT_W-1:0]      grant_cnt0,
    output logic [CNT_W-1:0]      grant_cnt1
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    localparam logic [3:0] c_MAX_LEGAL_OP = 4'd9;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_prio;
    logic                  r_owner;
    logic [DATA_W-1:0]     r_a;
    logic [DATA_W-1:0]     r_b;
    logic [3:0]            r_op;
    logic [DATA_W-1:0]     r_result;
    logic                  r_zero;
    logic                  r_illegal;
    logic [CNT_W-1:0]      r_cnt0;
    logic [CNT_W-1:0]      r_cnt1;

    logic                  w_grant;
    logic                  w_grant_id;
    logic [1:0]            w_req_ready;
    logic [1:0]            w_rsp_valid;

    // Acceptance is suppressed while rst is high so no requester sees a
    // handshake for a transaction that the reset is about to discard.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_grant_id  = 1'b0;
        w_req_ready = 2'b00;
        w_rsp_valid = 2'b00;
        case (r_state)
            IDLE: begin
                if (!rst && (req_valid != 2'b00)) begin
                    w_grant     = 1'b1;
                    w_grant_id  = (req_valid == 2'b11) ? r_prio : req_valid[1];
                    w_req_ready = w_grant_id ? 2'b10 : 2'b01;
                    w_state_nxt = EXEC;
                end
            end
            EXEC: begin
                w_state_nxt = RESP;
            end
            RESP: begin
                w_rsp_valid = r_owner ? 2'b10 : 2'b01;
                if (rsp_ready[r_owner]) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_prio    <= 1'b0;
            r_owner   <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_op      <= '0;
            r_result  <= '0;
            r_zero    <= 1'b0;
            r_illegal <= 1'b0;
            r_cnt0    <= '0;
            r_cnt1    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_owner <= w_grant_id;
                r_prio  <= ~w_grant_id;
                r_a     <= w_grant_id ? req_a[2*DATA_W-1:DATA_W] : req_a[DATA_W-1:0];
                r_b     <= w_grant_id ? req_b[2*DATA_W-1:DATA_W] : req_b[DATA_W-1:0];
                r_op    <= w_grant_id ? req_op[7:4] : req_op[3:0];
                // Counters stick at all-ones; the grant itself is unaffected.
                if (!w_grant_id && (r_cnt0 != '1)) begin
                    r_cnt0 <= r_cnt0 + 1'b1;
                end
                if (w_grant_id && (r_cnt1 != '1)) begin
                    r_cnt1 <= r_cnt1 + 1'b1;
                end
            end
            if (r_state == EXEC) begin
                r_result  <= alu_result;
                r_zero    <= alu_zero;
                r_illegal <= (r_op > c_MAX_LEGAL_OP);
            end
        end
    end

    assign req_ready   = w_req_ready;
    assign rsp_valid   = w_rsp_valid;
    assign rsp_result  = r_result;
    assign rsp_zero    = r_zero;
    assign rsp_illegal = r_illegal;
    assign alu_a       = r_a;
    assign alu_b       = r_b;
    assign alu_op      = r_op;
    assign busy        = (r_state != IDLE);
    assign grant_cnt0  = r_cnt0;
    assign grant_cnt1  = r_cnt1;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_share_arbiter
// Description : Scoreboard bench for alu_share_arbiter with a behavioural ALU
//               and a transaction-level arbitration model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_share_arbiter;

    localparam int DW   = 32;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
    } req_t;

    typedef struct {
        int          owner;
        logic [31:0] res;
        logic        zero;
        logic        ill;
        int          acc;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [1:0]      req_valid = 2'b00;
    logic [1:0]      req_ready;
    logic [2*DW-1:0] req_a = '0;
    logic [2*DW-1:0] req_b = '0;
    logic [7:0]      req_op = '0;
    logic [1:0]      rsp_valid;
    logic [1:0]      rsp_ready = 2'b00;
    logic [DW-1:0]   rsp_result;
    logic            rsp_zero;
    logic            rsp_illegal;
    logic [DW-1:0]   alu_a;
    logic [DW-1:0]   alu_b;
    logic [3:0]      alu_op;
    logic [DW-1:0]   alu_result;
    logic            alu_zero;
    logic            busy;
    logic [CW-1:0]   grant_cnt0;
    logic [CW-1:0]   grant_cnt1;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    req_t pend0[$];
    req_t pend1[$];
    exp_t sb[$];
    logic       rr_rand  = 1'b0;
    logic [1:0] rr_force = 2'b11;

    // Model state: transaction-level view of the arbiter
    int   m_prio  = 0;
    int   m_busy  = 0;
    int   m_owner = 0;
    int   m_cnt0  = 0;
    int   m_cnt1  = 0;

    alu_share_arbiter #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_illegal(rsp_illegal),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .busy(busy), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] alu_ref(logic [31:0] a, logic [31:0] b, logic [3:0] op);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << b[4:0];
            4'd6:    return a >> b[4:0];
            4'd7:    return $unsigned($signed(a) >>> b[4:0]);
            4'd8:    return {31'd0, $signed(a) < $signed(b)};
            4'd9:    return {31'd0, a < b};
            default: return 32'd0;
        endcase
    endfunction

    always_comb begin
        alu_result = alu_ref(alu_a, alu_b, alu_op);
        alu_zero   = (alu_result == '0);
    end

    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h cycle=%0d", name, got, exp, cyc);
        end
    endtask

    // Requester driver: holds each request until it is accepted.
    initial begin : drv
        logic [1:0] acc;
        req_t       r;
        forever begin
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (acc[i]) req_valid[i] = 1'b0;
                if (!req_valid[i] && (i == 0 ? pend0.size() : pend1.size()) > 0) begin
                    r = (i == 0) ? pend0.pop_front() : pend1.pop_front();
                    req_a[i*DW +: DW] = r.a;
                    req_b[i*DW +: DW] = r.b;
                    req_op[i*4 +: 4]  = r.op;
                    req_valid[i]      = 1'b1;
                end
            end
        end
    end

    initial begin : rr_drv
        forever begin
            @(posedge clk);
            #1;
            rsp_ready = rr_rand ? 2'($urandom) : rr_force;
        end
    end

    // Arbitration model: predicts grants, counters and busy; pushes expectations.
    always @(negedge clk) begin : model
        int         g;
        logic [1:0] exp_rdy;
        exp_t       e;
        if (rst) begin
            m_prio = 0; m_busy = 0; m_owner = 0; m_cnt0 = 0; m_cnt1 = 0;
        end else begin
            chk("busy", 64'(busy), 64'(m_busy));
            chk("grant_cnt0", 64'(grant_cnt0), 64'(m_cnt0));
            chk("grant_cnt1", 64'(grant_cnt1), 64'(m_cnt1));
            if (m_busy == 0) begin
                if (req_valid == 2'b00)      g = -1;
                else if (req_valid == 2'b11) g = m_prio;
                else                         g = req_valid[1] ? 1 : 0;
                exp_rdy = (g < 0) ? 2'b00 : ((g == 1) ? 2'b10 : 2'b01);
                chk("req_ready", 64'(req_ready), 64'(exp_rdy));
                if (g >= 0) begin
                    e.owner = g;
                    e.res   = alu_ref(req_a[g*DW +: DW], req_b[g*DW +: DW], req_op[g*4 +: 4]);
                    e.zero  = (e.res == 32'd0);
                    e.ill   = (req_op[g*4 +: 4] > 4'd9);
                    e.acc   = cyc;
                    sb.push_back(e);
                    m_prio  = 1 - g;
                    m_owner = g;
                    m_busy  = 1;
                    if (g == 0 && m_cnt0 < CMAX) m_cnt0++;
                    if (g == 1 && m_cnt1 < CMAX) m_cnt1++;
                end
            end else begin
                chk("req_ready_busy", 64'(req_ready), 64'd0);
                if (rsp_valid[m_owner] && rsp_ready[m_owner]) m_busy = 0;
            end
        end
    end

    // Response monitor: pops expectations on each response handshake.
    always @(negedge clk) begin : monitor
        exp_t       e;
        logic [1:0] oh;
        if (rst) begin
            sb.delete();
        end else if (sb.size() == 0) begin
            chk("rsp_valid_idle", 64'(rsp_valid), 64'd0);
        end else begin
            e  = sb[0];
            oh = (e.owner == 1) ? 2'b10 : 2'b01;
            if (cyc < e.acc + 2) begin
                chk("rsp_valid_early", 64'(rsp_valid), 64'd0);
            end else begin
                chk("rsp_valid", 64'(rsp_valid), 64'(oh));
                chk("rsp_result", 64'(rsp_result), 64'(e.res));
                chk("rsp_zero", 64'(rsp_zero), 64'(e.zero));
                chk("rsp_illegal", 64'(rsp_illegal), 64'(e.ill));
                if (rsp_valid[e.owner] && rsp_ready[e.owner]) void'(sb.pop_front());
            end
        end
    end

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((pend0.size() != 0 || pend1.size() != 0 || req_valid != 2'b00 ||
                sb.size() != 0 || busy) && n < 400) begin
            step(1);
            n++;
        end
        checks++;
        if (n >= 400) begin
            failures++;
            $display("FAIL wait_idle: got=timeout expected=drained cycle=%0d", cyc);
        end
        step(1);
    endtask

    task automatic wait_accept(int i);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(req_valid[i] && req_ready[i]) && n < 50);
        checks++;
        if (n >= 50) begin
            failures++;
            $display("FAIL wait_accept: got=timeout expected=grant%0d cycle=%0d", i, cyc);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        step(3);
        rst = 1'b0;
        step(2);

        // Single request, add
        rr_force = 2'b11;
        pend0.push_back('{32'd5, 32'd7, 4'd0});
        wait_idle();

        // Contention: strict alternation from prio 0
        do_reset();
        for (int k = 0; k < 2; k++) begin
            pend0.push_back('{32'd9, 32'd9, 4'd1});
            pend1.push_back('{32'd3, 32'd1, 4'd5});
        end
        wait_idle();
        chk("cnt0_after_alt", 64'(grant_cnt0), 64'd2);
        chk("cnt1_after_alt", 64'(grant_cnt1), 64'd2);

        // Backpressure on requester 1, with requester 0 waiting
        rr_force = 2'b00;
        pend1.push_back('{32'h8000_0000, 32'd4, 4'd7});
        step(3);
        pend0.push_back('{32'd2, 32'd3, 4'd0});
        step(3);
        rr_force = 2'b01;
        step(2);
        rr_force = 2'b11;
        wait_idle();

        // Illegal op
        pend0.push_back('{32'd1, 32'd1, 4'd15});
        wait_idle();

        // Reset while in EXEC, then contention must favour requester 0
        pend1.push_back('{32'd10, 32'd20, 4'd0});
        pend1.push_back('{32'd11, 32'd4, 4'd1});
        wait_accept(1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        pend0.push_back('{32'd6, 32'd6, 4'd4});
        wait_idle();

        // Reset while in RESP
        rr_force = 2'b00;
        pend1.push_back('{32'd12, 32'd3, 4'd6});
        wait_accept(1);
        step(1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        rr_force = 2'b11;
        pend0.push_back('{32'd7, 32'd8, 4'd9});
        pend1.push_back('{32'd7, 32'd8, 4'd8});
        wait_idle();

        // Counter saturation
        do_reset();
        for (int k = 1; k <= 5; k++) pend0.push_back('{32'(k), 32'(k), 4'd0});
        wait_idle();
        chk("cnt0_saturated", 64'(grant_cnt0), 64'(CMAX));

        // Randomized traffic with random response backpressure
        rr_rand = 1'b1;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 3) == 0 && pend0.size() < 2)
                pend0.push_back('{$urandom, $urandom, 4'($urandom_range(0, 15))});
            if ($urandom_range(0, 3) == 0 && pend1.size() < 2)
                pend1.push_back('{$urandom, 32'($urandom_range(0, 40)), 4'($urandom_range(0, 15))});
            step(1);
        end
        wait_idle();
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
